alu_share_arb: RTL and testbench

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu.sv | 51 +++++
 rtl/alu_share_arb.sv | 142 ++++++++++++++
 tb/tb_alu_share_arb.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: ALU operation codes,
// arbiter FSM state encoding and the datapath width.
package alu_pkg;

    localparam int DATA_W = 32;

    // ALU operation encodings; codes not listed here make the ALU return zero
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. The overflow flag reports signed overflow for
// ADD and SUB and is zero for every other operation.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]        ALUop,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              over,
    output logic [DATA_W-1:0] C
);

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic        [DATA_W-1:0] sum;
    logic        [DATA_W-1:0] diff;

    assign a_s  = A;
    assign b_s  = B;
    assign sum  = A + B;
    assign diff = A - B;

    // Operation decode; undefined codes fall through to zero result
    always_comb begin
        C    = '0;
        over = 1'b0;
        case (ALUop)
            ALU_ADD: begin
                C    = sum;
                over = (A[DATA_W-1] == B[DATA_W-1]) && (sum[DATA_W-1] != A[DATA_W-1]);
            end
            ALU_SUB: begin
                C    = diff;
                over = (A[DATA_W-1] != B[DATA_W-1]) && (diff[DATA_W-1] != A[DATA_W-1]);
            end
            ALU_AND:  C = A & B;
            ALU_OR:   C = A | B;
            ALU_XOR:  C = A ^ B;
            ALU_SLL:  C = A << B[4:0];
            ALU_SRL:  C = A >> B[4:0];
            ALU_SRA:  C = $unsigned(a_s >>> B[4:0]);
            ALU_SLT:  C = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: C = {{(DATA_W-1){1'b0}}, (A < B)};
            default: begin
                C    = '0;
                over = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Two-port arbiter sharing a single ALU. Each accepted operation goes
// IDLE -> EXEC -> HOLD; the result is presented on the granted port until
// that port handshakes it.
// Optional feature: define ALU_ARB_RR_EN for round-robin arbitration between
// simultaneous requests; otherwise port 0 always has priority.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int NPORT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_c,
    output logic              rsp0_over,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_c,
    output logic              rsp1_over
);

    state_t            state;
    state_t            state_nxt;
    logic [NPORT-1:0]  req_vec;
    logic              any_valid;
    logic              grant_sel;   // 0 = port 0, 1 = port 1
    logic              grant_q;     // port owning the in-flight operation
    logic              rsp_hs;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] alu_c;
    logic              alu_over;
    logic [DATA_W-1:0] res_c;
    logic              res_over;

    assign req_vec   = {req1_valid, req0_valid};
    assign any_valid = |req_vec;
    assign rsp_hs    = grant_q ? rsp1_ready : rsp0_ready;

`ifdef ALU_ARB_RR_EN
    logic last_grant;

    // Round-robin: on contention grant the port that did not win last time
    always_comb begin
        if (&req_vec) grant_sel = ~last_grant;
        else          grant_sel = ~req_vec[0];
    end

    // Remember the winner of every accept; resets to port 1 so port 0 wins first
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              last_grant <= 1'b1;
        else if (state == ST_IDLE && any_valid) last_grant <= grant_sel;
    end
`else
    // Fixed priority: port 0 wins whenever it is valid
    assign grant_sel = ~req_vec[0];
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_valid) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_HOLD;
            ST_HOLD: if (rsp_hs) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE for the winner, valid only in HOLD for the owner
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        if (state == ST_IDLE && !reset) begin
            req0_ready = any_valid && !grant_sel;
            req1_ready = any_valid &&  grant_sel;
        end
        if (state == ST_HOLD) begin
            rsp0_valid = !grant_q;
            rsp1_valid =  grant_q;
        end
    end

    // Operand capture on accept and result capture in EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            grant_q  <= 1'b0;
            res_c    <= '0;
            res_over <= 1'b0;
        end else begin
            if (state == ST_IDLE && any_valid) begin
                grant_q <= grant_sel;
                op_q    <= grant_sel ? req1_op : req0_op;
                a_q     <= grant_sel ? req1_a  : req0_a;
                b_q     <= grant_sel ? req1_b  : req0_b;
            end
            if (state == ST_EXEC) begin
                res_c    <= alu_c;
                res_over <= alu_over;
            end
        end
    end

    // The shared ALU sees only the registered operands
    alu u_alu (
        .ALUop (op_q),
        .A     (a_q),
        .B     (b_q),
        .over  (alu_over),
        .C     (alu_c)
    );

    // Result lines carry the held result only on the port that owns it
    assign rsp0_c    = rsp0_valid ? res_c    : '0;
    assign rsp0_over = rsp0_valid ? res_over : 1'b0;
    assign rsp1_c    = rsp1_valid ? res_c    : '0;
    assign rsp1_over = rsp1_valid ? res_over : 1'b0;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed testbench for alu_share_arb. Honours ALU_ARB_RR_EN for the
// expected contention grant order.
module tb_alu_share_arb;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_c, rsp1_c;
    logic        rsp0_over, rsp1_over;

    int n_vec = 0;
    int n_err = 0;

    alu_share_arb #(.NPORT(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_c     (rsp0_c),
        .rsp0_over  (rsp0_over),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_c     (rsp1_c),
        .rsp1_over  (rsp1_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One uncontended transaction on port p with immediate response handshake
    task automatic do_txn(input int p, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ec, input logic eo,
                          input string tag);
        if (p == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        #1;
        chk({tag, "_rdy0"}, req0_ready, p == 0);
        chk({tag, "_rdy1"}, req1_ready, p == 1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk({tag, "_exec_vld"}, rsp0_valid | rsp1_valid, 0);
        @(posedge clk); #1;
        chk({tag, "_vld0"}, rsp0_valid, p == 0);
        chk({tag, "_vld1"}, rsp1_valid, p == 1);
        chk({tag, "_c"},    (p == 0) ? rsp0_c : rsp1_c, ec);
        chk({tag, "_over"}, (p == 0) ? rsp0_over : rsp1_over, eo);
        if (p == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        chk({tag, "_done"}, rsp0_valid | rsp1_valid, 0);
    endtask

    initial begin
        int ep;
        reset      = 1'b1;
        req0_valid = 1'b1;  // valid during reset must not be accepted
        req1_valid = 1'b0;
        req0_op = '0; req0_a = '0; req0_b = '0;
        req1_op = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        chk("rst_vld0", rsp0_valid, 0);
        chk("rst_vld1", rsp1_valid, 0);
        chk("rst_c0",   rsp0_c, 0);
        chk("rst_over0", rsp0_over, 0);

        // Single request, first IDLE cycle after release, held result
        @(posedge clk); #1;
        reset = 1'b0;
        req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd10; req0_b = 32'd2;
        #1;
        chk("add_rdy0", req0_ready, 1);
        chk("add_rdy1", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        #1;
        chk("add_exec_vld0", rsp0_valid, 0);
        chk("add_exec_rdy0", req0_ready, 0);
        @(posedge clk); #1;
        chk("add_vld0", rsp0_valid, 1);
        chk("add_c",    rsp0_c, 32'd12);
        chk("add_over", rsp0_over, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("add_hold_vld", rsp0_valid, 1);
            chk("add_hold_c",   rsp0_c, 32'd12);
        end
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        #1;
        chk("add_done_vld0", rsp0_valid, 0);

        // Overflow on port 1, plus a few other operations
        do_txn(1, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, "ovf_add");
        do_txn(0, ALU_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, "ovf_sub");
        do_txn(1, 4'hF,    32'd1,         32'd2, 32'h0,         1'b0, "undef");
        do_txn(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'h1,         1'b0, "slt");

        // Contention: both valid for four transactions
        req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd100; req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = ALU_SUB; req1_a = 32'd100; req1_b = 32'd1;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
            ep = i % 2;
`else
            ep = 0;
`endif
            #1;
            chk("cont_rdy0", req0_ready, ep == 0);
            chk("cont_rdy1", req1_ready, ep == 1);
            @(posedge clk); #1;
            chk("cont_exec_rdy", req0_ready | req1_ready, 0);
            @(posedge clk); #1;
            chk("cont_hold_rdy", req0_ready | req1_ready, 0);
            chk("cont_vld0", rsp0_valid, ep == 0);
            chk("cont_vld1", rsp1_valid, ep == 1);
            chk("cont_c", (ep == 0) ? rsp0_c : rsp1_c, (ep == 0) ? 32'd101 : 32'd99);
            if (ep == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
            @(posedge clk); #1;
            rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;

        // Backpressure: port 1 waits while port 0 result is held
        req0_valid = 1'b1; req0_op = ALU_SUB; req0_a = 32'd50; req0_b = 32'd8;
        #1;
        chk("bp_rdy0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = ALU_AND; req1_a = 32'hFFFF_0000; req1_b = 32'h1234_5678;
        #1;
        chk("bp_exec_rdy1", req1_ready, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_rdy1", req1_ready, 0);
            chk("bp_hold_vld0", rsp0_valid, 1);
            @(posedge clk); #1;
        end
        chk("bp_c0", rsp0_c, 32'd42);
        chk("bp_rdy1_pre", req1_ready, 0);
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        #1;
        chk("bp_rdy1_idle", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_vld1", rsp1_valid, 1);
        chk("bp_c1", rsp1_c, 32'h1234_0000);
        rsp1_ready = 1'b1;
        @(posedge clk); #1;
        rsp1_ready = 1'b0;

        // Reset during EXEC discards the operation
        req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd5; req0_b = 32'd3;
        #1;
        chk("mid_rdy0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        reset = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("mid_rst_vld0", rsp0_valid, 0);
        chk("mid_rst_vld1", rsp1_valid, 0);
        chk("mid_rst_rdy1", req1_ready, 0);
        chk("mid_rst_c0",   rsp0_c, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mid_post_vld", rsp0_valid | rsp1_valid, 0);
        end
        do_txn(0, ALU_XOR, 32'd5, 32'd3, 32'd6, 1'b0, "mid_new");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
